// File: rtl/inst_fetch_unit.sv
// ============================================================================
// inst_fetch_unit
// ----------------------------------------------------------------------------
// Instruction-side producer for the single-cycle MIPS control path. It keeps
// the PC and fetches one word per step from instruction memory over a
// req/ack handshake. The fetched word is held and shown to the decoder as
// Inst/Op/Func. When the core retires the held word (Adv), the decoder's
// Pcsrc selects the next PC (PC+4, branch or jump) and the next fetch starts.
//
// Parameters:
//   RESET_PC    - PC after reset (bits [1:0] forced to 00)
//   TIMEOUT_CYC - fetch watchdog limit in cycles (only with IFU_TIMEOUT_EN)
//
// Optional feature macro: IFU_TIMEOUT_EN
//   defined   - a fetch that goes unanswered for TIMEOUT_CYC cycles is
//               replaced by a NOP and the sticky Fault flag is set
//   undefined - FETCH waits indefinitely; Fault is constant 0
//
// Ports:
//   Clk         in   1   clock, rising edge
//   Clrn        in   1   asynchronous active-low reset
//   Pcsrc       in   2   next-PC select: 00/11 PC+4, 01 branch, 10 jump
//   Imm         in   32  sign-extended immediate (branch offset in words)
//   Adv         in   1   core retired the held instruction
//   Imem_req    out  1   fetch request (registered)
//   Imem_addr   out  32  fetch address (registered, word aligned)
//   Imem_ack    in   1   memory returns Imem_rdata this cycle
//   Imem_rdata  in   32  instruction word
//   Inst        out  32  held instruction
//   Op          out  6   Inst[31:26]
//   Func        out  6   Inst[5:0]
//   Inst_valid  out  1   Inst holds a fetched, unretired word
//   Pc          out  32  address of the held / in-flight instruction
//   Fault       out  1   sticky fetch timeout flag
// ============================================================================
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic [1:0]  Pcsrc,
    input  logic [31:0] Imm,
    input  logic        Adv,
    output logic        Imem_req,
    output logic [31:0] Imem_addr,
    input  logic        Imem_ack,
    input  logic [31:0] Imem_rdata,
    output logic [31:0] Inst,
    output logic [5:0]  Op,
    output logic [5:0]  Func,
    output logic        Inst_valid,
    output logic [31:0] Pc,
    output logic        Fault
);

    localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetchState_t;

    fetchState_t state_q;
    logic [31:0] pc_q;
    logic [31:0] imemAddr_q;
    logic        imemReq_q;
    logic [31:0] inst_q;
    logic        instValid_q;
    logic [31:0] pc_d;
    logic [31:0] pcPlus4;

`ifdef IFU_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYC + 1);
    logic [CntW-1:0] timeoutCnt_q;
    logic            fault_q;
`endif

    // Only the low 30 immediate bits survive the word-offset shift, and the
    // watchdog limit is unused when the timeout feature is compiled out.
    logic unusedBits;
    assign unusedBits = ^{Imm[31:30], 32'(TIMEOUT_CYC)};

    // Next PC from the decoder's selection. The jump form keeps the 256 MB
    // region of PC+4 and replaces the rest with the held instruction's
    // 26-bit target; everything wraps modulo 2^32.
    always_comb begin
        pcPlus4 = pc_q + 32'd4;
        pc_d    = pcPlus4;
        case (Pcsrc)
            2'b01:   pc_d = pcPlus4 + {Imm[29:0], 2'b00};
            2'b10:   pc_d = {pcPlus4[31:28], inst_q[25:0], 2'b00};
            default: pc_d = pcPlus4;
        endcase
    end

    // Fetch sequencer: IDLE issues the very first request after reset,
    // FETCH holds req/addr stable until the ack, HOLD keeps the word valid
    // until the core retires it. Adv outside HOLD and ack outside FETCH are
    // simply not looked at; in HOLD an ack alongside Adv is ignored.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q      <= IDLE;
            pc_q         <= ResetPcAligned;
            imemAddr_q   <= ResetPcAligned;
            imemReq_q    <= 1'b0;
            inst_q       <= 32'h0000_0000;
            instValid_q  <= 1'b0;
`ifdef IFU_TIMEOUT_EN
            timeoutCnt_q <= '0;
            fault_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    imemReq_q    <= 1'b1;
                    imemAddr_q   <= pc_q;
                    state_q      <= FETCH;
`ifdef IFU_TIMEOUT_EN
                    timeoutCnt_q <= '0;
`endif
                end
                FETCH: begin
                    if (Imem_ack) begin
                        inst_q      <= Imem_rdata;
                        instValid_q <= 1'b1;
                        imemReq_q   <= 1'b0;
                        state_q     <= HOLD;
                    end
`ifdef IFU_TIMEOUT_EN
                    // This edge ends the TIMEOUT_CYC-th unanswered cycle, so
                    // a NOP is substituted; an ack on this same edge wins.
                    else if (timeoutCnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                        inst_q      <= 32'h0000_0000;
                        instValid_q <= 1'b1;
                        imemReq_q   <= 1'b0;
                        fault_q     <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        timeoutCnt_q <= timeoutCnt_q + CntW'(1);
                    end
`endif
                end
                HOLD: begin
                    if (Adv) begin
                        pc_q         <= pc_d;
                        imemAddr_q   <= pc_d;
                        imemReq_q    <= 1'b1;
                        instValid_q  <= 1'b0;
                        state_q      <= FETCH;
`ifdef IFU_TIMEOUT_EN
                        timeoutCnt_q <= '0;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Imem_req   = imemReq_q;
    assign Imem_addr  = imemAddr_q;
    assign Inst       = inst_q;
    assign Op         = inst_q[31:26];
    assign Func       = inst_q[5:0];
    assign Inst_valid = instValid_q;
    assign Pc         = pc_q;
`ifdef IFU_TIMEOUT_EN
    assign Fault      = fault_q;
`else
    assign Fault      = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ============================================================================
// tb_inst_fetch_unit
// ----------------------------------------------------------------------------
// Bench for inst_fetch_unit: directed scenarios for reset, latency, branch,
// jump, wrap-around and reset mid-fetch, followed by randomized transactions
// checked against a transaction-level PC model.
// ============================================================================
module tb_inst_fetch_unit;

    logic        Clk;
    logic        Clrn;
    logic [1:0]  Pcsrc;
    logic [31:0] Imm;
    logic        Adv;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ack;
    logic [31:0] Imem_rdata;
    logic [31:0] Inst;
    logic [5:0]  Op;
    logic [5:0]  Func;
    logic        Inst_valid;
    logic [31:0] Pc;
    logic        Fault;

    int testCount = 0;
    int failCount = 0;

    inst_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .TIMEOUT_CYC(16)
    ) dut (
        .Clk       (Clk),
        .Clrn      (Clrn),
        .Pcsrc     (Pcsrc),
        .Imm       (Imm),
        .Adv       (Adv),
        .Imem_req  (Imem_req),
        .Imem_addr (Imem_addr),
        .Imem_ack  (Imem_ack),
        .Imem_rdata(Imem_rdata),
        .Inst      (Inst),
        .Op        (Op),
        .Func      (Func),
        .Inst_valid(Inst_valid),
        .Pc        (Pc),
        .Fault     (Fault)
    );

    // Free-running 10 ns clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic adv, input logic [1:0] pcsrc,
                                 input logic [31:0] imm, input logic ack,
                                 input logic [31:0] rdata);
        Adv        = adv;
        Pcsrc      = pcsrc;
        Imm        = imm;
        Imem_ack   = ack;
        Imem_rdata = rdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Unit is fetching 'addr': request raised, nothing valid held.
    task automatic expectFetch(input string tag, input logic [31:0] addr);
        checkOutput({tag, " req"}, {31'd0, Imem_req}, 32'd1);
        checkOutput({tag, " addr"}, Imem_addr, addr);
        checkOutput({tag, " pc"}, Pc, addr);
        checkOutput({tag, " valid"}, {31'd0, Inst_valid}, 32'd0);
    endtask

    // Unit holds 'inst' fetched from 'pc'.
    task automatic expectHold(input string tag, input logic [31:0] pc,
                              input logic [31:0] inst);
        checkOutput({tag, " req"}, {31'd0, Imem_req}, 32'd0);
        checkOutput({tag, " valid"}, {31'd0, Inst_valid}, 32'd1);
        checkOutput({tag, " inst"}, Inst, inst);
        checkOutput({tag, " op"}, {26'd0, Op}, inst >> 26);
        checkOutput({tag, " func"}, {26'd0, Func}, inst & 32'h0000_003F);
        checkOutput({tag, " pc"}, Pc, pc);
    endtask

    // Architectural next-PC rule, written as plain address arithmetic.
    function automatic logic [31:0] nextPcModel(input logic [31:0] pc,
                                                input logic [1:0] sel,
                                                input logic [31:0] imm,
                                                input logic [31:0] inst);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (sel == 2'b01) return seq + imm * 32'd4;
        if (sel == 2'b10) return (seq & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) << 2);
        return seq;
    endfunction

    // Directed scenarios, then randomized transactions against the model.
    initial begin
        logic [31:0] expPc;
        logic [31:0] heldInst;
        logic [31:0] rdata;
        logic [31:0] imm;
        logic [1:0]  sel;

        Clrn = 1'b0;
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b0, 32'd0);
        #2;
        checkOutput("reset req", {31'd0, Imem_req}, 32'd0);
        checkOutput("reset addr", Imem_addr, 32'd0);
        checkOutput("reset inst", Inst, 32'd0);
        checkOutput("reset valid", {31'd0, Inst_valid}, 32'd0);
        checkOutput("reset pc", Pc, 32'd0);
        checkOutput("reset fault", {31'd0, Fault}, 32'd0);
        step();
        step();
        checkOutput("reset held req", {31'd0, Imem_req}, 32'd0);

        // First fetch, acked in its first request cycle.
        Clrn = 1'b1;
        step();
        expectFetch("first fetch", 32'h0000_0000);
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b1, 32'h2008_0005);
        step();
        expectHold("first hold", 32'h0000_0000, 32'h2008_0005);
        checkOutput("first op", {26'd0, Op}, 32'b001000);

        // Branch to 0x80, then reset while that fetch is outstanding.
        applyStimulus(1'b1, 2'b01, 32'h0000_001F, 1'b0, 32'd0);
        step();
        expectFetch("branch 0x80", 32'h0000_0080);
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b0, 32'd0);
        step();
        expectFetch("fetch 0x80 wait", 32'h0000_0080);
        Clrn = 1'b0;
        #1;
        checkOutput("midreset req", {31'd0, Imem_req}, 32'd0);
        checkOutput("midreset addr", Imem_addr, 32'd0);
        checkOutput("midreset pc", Pc, 32'd0);
        step();
        Clrn = 1'b1;
        step();
        expectFetch("restart", 32'h0000_0000);

        // Jump from 0 to 0x40, then branch back by two words to 0x3C.
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b1, 32'h0800_0010);
        step();
        expectHold("jump src", 32'h0000_0000, 32'h0800_0010);
        applyStimulus(1'b1, 2'b10, 32'd0, 1'b0, 32'd0);
        step();
        expectFetch("jump 0x40", 32'h0000_0040);
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b1, 32'h1111_2222);
        step();
        expectHold("hold 0x40", 32'h0000_0040, 32'h1111_2222);
        applyStimulus(1'b1, 2'b01, 32'hFFFF_FFFE, 1'b0, 32'd0);
        step();
        expectFetch("branch back", 32'h0000_003C);
        checkOutput("inst kept", Inst, 32'h1111_2222);
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b1, 32'h3333_4444);
        step();
        applyStimulus(1'b1, 2'b00, 32'd0, 1'b0, 32'd0);
        step();
        expectFetch("seq 0x40", 32'h0000_0040);
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b1, 32'h5555_6666);
        step();
        applyStimulus(1'b1, 2'b00, 32'hFFFF_FFFE, 1'b0, 32'd0);
        step();
        expectFetch("seq 0x44", 32'h0000_0044);

        // Branch into the 0x1000_0000 region, then jump within it while a
        // stray ack arrives alongside Adv.
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b1, 32'h7777_8888);
        step();
        applyStimulus(1'b1, 2'b01, (32'h1000_0000 - 32'h0000_0048) >> 2, 1'b0, 32'd0);
        step();
        expectFetch("far branch", 32'h1000_0000);
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b1, 32'h0800_0010);
        step();
        expectHold("far hold", 32'h1000_0000, 32'h0800_0010);
        applyStimulus(1'b1, 2'b10, 32'd0, 1'b1, 32'hDEAD_BEEF);
        step();
        expectFetch("jump region", 32'h1000_0040);
        checkOutput("adv+ack inst", Inst, 32'h0800_0010);

        // Ack delayed three cycles with Adv pulsing during FETCH.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(i != 1, 2'b10, 32'h0000_0100, 1'b0, 32'hCAFE_0000);
            step();
            expectFetch("ack delay", 32'h1000_0040);
        end
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b1, 32'h2400_0001);
        step();
        expectHold("late ack", 32'h1000_0040, 32'h2400_0001);

        // Ack in HOLD without Adv must not disturb the held word.
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b1, 32'hBAD0_BAD0);
        step();
        expectHold("hold ack", 32'h1000_0040, 32'h2400_0001);

        // Reach the top word and wrap to 0.
        applyStimulus(1'b1, 2'b01, (32'hFFFF_FFFC - 32'h1000_0044) >> 2, 1'b0, 32'd0);
        step();
        expectFetch("top word", 32'hFFFF_FFFC);
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b1, 32'h0000_0020);
        step();
        applyStimulus(1'b1, 2'b00, 32'd0, 1'b0, 32'd0);
        step();
        expectFetch("wrap", 32'h0000_0000);

        // Randomized transactions.
        expPc = 32'h0000_0000;
        for (int n = 0; n < 150; n++) begin
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
                applyStimulus(1'($urandom), 2'($urandom), $urandom, 1'b0, $urandom);
                step();
                expectFetch("rnd wait", expPc);
            end
            rdata = $urandom;
            applyStimulus(1'($urandom), 2'($urandom), $urandom, 1'b1, rdata);
            step();
            heldInst = rdata;
            expectHold("rnd hold", expPc, heldInst);
            for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
                applyStimulus(1'b0, 2'($urandom), $urandom, 1'($urandom), $urandom);
                step();
                expectHold("rnd stay", expPc, heldInst);
            end
            sel = 2'($urandom);
            imm = {{16{1'($urandom)}}, 16'($urandom)};
            applyStimulus(1'b1, sel, imm, 1'($urandom), $urandom);
            step();
            expPc = nextPcModel(expPc, sel, imm, heldInst);
            expectFetch("rnd next", expPc);
            checkOutput("rnd inst kept", Inst, heldInst);
        end

`ifdef IFU_TIMEOUT_EN
        // Unanswered fetch: NOP substituted after 16 cycles, Fault sticks.
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b0, 32'hFFFF_FFFF);
        for (int c = 0; c < 15; c++) begin
            step();
            expectFetch("timeout wait", expPc);
        end
        step();
        expectHold("timeout nop", expPc, 32'h0000_0000);
        checkOutput("timeout fault", {31'd0, Fault}, 32'd1);
        applyStimulus(1'b1, 2'b00, 32'd0, 1'b0, 32'd0);
        step();
        expPc = expPc + 32'd4;
        expectFetch("after timeout", expPc);
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b1, 32'h1234_5678);
        step();
        expectHold("after timeout hold", expPc, 32'h1234_5678);
        checkOutput("fault sticky", {31'd0, Fault}, 32'd1);
`else
        // Without the watchdog the fetch waits indefinitely.
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b0, 32'hFFFF_FFFF);
        for (int c = 0; c < 20; c++) begin
            step();
            expectFetch("no timeout", expPc);
        end
        checkOutput("fault zero", {31'd0, Fault}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
